uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_rx_os.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_os.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: 2-flop synchronised line, glitch-rejecting start, optional parity; data registered one clk after the mid-stop tick.
// Backpressure: one holding register; a good frame arriving while it is full and not being drained is dropped with an overrun pulse.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 sync1_q, rxs_q;
  logic                 par_q, par_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;
  logic                 good, exp_par, parity_bad, mid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
    ovr_d      = 1'b0;
    good       = 1'b0;
    mid        = (cnt_q == CNT_FULL);
    exp_par    = (^shift_q) ^ (PARITY_ODD != 0);
    parity_bad = (PARITY_EN != 0) && (par_q != exp_par);

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        // Re-check the line at the middle of the start bit to reject glitches.
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rxs_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (mid) begin
            cnt_d   = '0;
            shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (mid) begin
            cnt_d   = '0;
            par_d   = rxs_q;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // A low stop bit takes precedence over a parity mismatch.
        S_STOP: begin
          if (mid) begin
            cnt_d = '0;
            if (rxs_q) begin
              state_d = S_IDLE;
              if (parity_bad) perr_d = 1'b1;
              else            good   = 1'b1;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rxs_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (good && (!valid_q || rx_ready)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else begin
      if (valid_q && rx_ready) valid_d = 1'b0;
      if (good)                ovr_d   = 1'b1;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 instance and an 8E1 instance share clock, reset and a tick every 4 clk.
module tb_uart_rx_os;
  logic       clk = 1'b0;
  logic       rst_n, tick, rx_a, rx_b, rdy_a, rdy_b;
  logic [7:0] data_a, data_b;
  logic       vld_a, vld_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

  int total = 0, bad = 0;
  int fe_cnt[2], pe_cnt[2], ov_cnt[2], rise_cnt[2];
  logic [7:0] got_a[$], got_b[$], exp_a[$], exp_b[$];

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst_n), .tick(tick), .rx(rx_a), .rx_data(data_a), .rx_valid(vld_a),
    .rx_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst(rst_n), .tick(tick), .rx(rx_b), .rx_data(data_b), .rx_valid(vld_b),
    .rx_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    if (inst != 0) rx_b = v; else rx_a = v;
  endtask

  task automatic set_rdy(input int inst, input logic v);
    if (inst != 0) rdy_b = v; else rdy_a = v;
  endtask

  task automatic wait_tick_edge();
    @(posedge clk);
    while (tick !== 1'b1) @(posedge clk);
  endtask

  // Start bit begins just after a tick edge P, so the mid-stop tick lands at
  // P + 36 + 64*(bits before stop); this returns one negedge before it.
  task automatic send_head(input int inst, input logic [7:0] d, input logic par, input logic stop);
    wait_tick_edge();
    @(negedge clk);
    set_rx(inst, 1'b0);
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(inst, d[i]);
      repeat (64) @(negedge clk);
    end
    if (inst != 0) begin
      set_rx(inst, par);
      repeat (64) @(negedge clk);
    end
    set_rx(inst, stop);
    repeat (35) @(negedge clk);
  endtask

  task automatic do_frame(input int inst, input logic [7:0] d, input logic par, input logic stop,
                          input logic rdy_done, input int extra_low,
                          output logic pre_v, output logic v, output logic [7:0] dat,
                          output logic f, output logic p, output logic o);
    logic rdy_prev;
    send_head(inst, d, par, stop);
    pre_v    = (inst != 0) ? vld_b : vld_a;
    rdy_prev = (inst != 0) ? rdy_b : rdy_a;
    if (rdy_done) set_rdy(inst, 1'b1);
    @(negedge clk);
    set_rdy(inst, rdy_prev);
    v   = (inst != 0) ? vld_b  : vld_a;
    dat = (inst != 0) ? data_b : data_a;
    f   = (inst != 0) ? fe_b   : fe_a;
    p   = (inst != 0) ? pe_b   : pe_a;
    o   = (inst != 0) ? ov_b   : ov_a;
    repeat (28 + extra_low) @(negedge clk);
    set_rx(inst, 1'b1);
    repeat (128) @(negedge clk);
  endtask

  // Monitor: pulse counters, accepted-data capture, holding-register stability.
  logic [7:0] pd[2];
  logic       pv[2];
  always @(posedge clk) begin
    logic [7:0] d[2];
    logic v[2], r[2], f[2], p[2], o[2];
    #1;
    d = '{data_a, data_b}; v = '{vld_a, vld_b}; r = '{rdy_a, rdy_b};
    f = '{fe_a, fe_b};     p = '{pe_a, pe_b};   o = '{ov_a, ov_b};
    if (!rst_n) begin
      pv = '{1'b0, 1'b0};
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (pv[k] && r[k]) begin
          if (k == 0) got_a.push_back(pd[k]); else got_b.push_back(pd[k]);
        end
        if (pv[k] && !r[k]) begin
          chk("hold_vld", v[k], 1);
          chk("hold_dat", d[k], pd[k]);
        end
        if (v[k] && !pv[k]) rise_cnt[k]++;
        fe_cnt[k] += int'(f[k]);
        pe_cnt[k] += int'(p[k]);
        ov_cnt[k] += int'(o[k]);
        pv[k] = v[k];
        pd[k] = d[k];
      end
    end
  end

  initial begin
    logic pre, v, f, p, o, stop, par;
    logic [7:0] dat, d;
    int n_fe, n_ov, n_rise, inst, kind;
    bit good, bad_par;

    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_data_a", data_a, 0); chk("rst_vld_a", vld_a, 0);
    chk("rst_fe_a", fe_a, 0);     chk("rst_pe_a", pe_a, 0);   chk("rst_ov_a", ov_a, 0);
    chk("rst_data_b", data_b, 0); chk("rst_vld_b", vld_b, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 8N1 0xA5, exact latency, then drain
    do_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, 0, pre, v, dat, f, p, o);
    chk("a5_pre_vld", pre, 0); chk("a5_vld", v, 1); chk("a5_dat", dat, 8'hA5);
    chk("a5_fe", f, 0); chk("a5_pe", p, 0); chk("a5_ov", o, 0);
    rdy_a = 1'b1;
    @(negedge clk);
    chk("a5_drain", vld_a, 0);
    exp_a.push_back(8'hA5);

    // start-bit glitch of 3 ticks
    n_fe = fe_cnt[0]; n_ov = ov_cnt[0]; n_rise = rise_cnt[0];
    wait_tick_edge();
    @(negedge clk);
    rx_a = 1'b0;
    repeat (12) @(negedge clk);
    rx_a = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_rise", rise_cnt[0] - n_rise, 0);
    chk("glitch_fe", fe_cnt[0] - n_fe, 0);
    chk("glitch_ov", ov_cnt[0] - n_ov, 0);
    do_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0, 0, pre, v, dat, f, p, o);
    chk("3c_vld", v, 1); chk("3c_dat", dat, 8'h3C);
    exp_a.push_back(8'h3C);

    // bad stop then a 40-tick break
    n_fe = fe_cnt[0]; n_rise = rise_cnt[0];
    do_frame(0, 8'h7E, 1'b0, 1'b0, 1'b0, 160, pre, v, dat, f, p, o);
    chk("7e_fe", f, 1); chk("7e_vld", v, 0); chk("7e_pe", p, 0);
    chk("brk_fe_count", fe_cnt[0] - n_fe, 1);
    chk("brk_rise", rise_cnt[0] - n_rise, 0);
    do_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 0, pre, v, dat, f, p, o);
    chk("11_vld", v, 1); chk("11_dat", dat, 8'h11); chk("11_fe", f, 0);
    exp_a.push_back(8'h11);

    // even parity on instance B
    do_frame(1, 8'h03, 1'b1, 1'b1, 1'b0, 0, pre, v, dat, f, p, o);
    chk("par_bad_pe", p, 1); chk("par_bad_vld", v, 0); chk("par_bad_fe", f, 0);
    do_frame(1, 8'h03, 1'b0, 1'b1, 1'b0, 0, pre, v, dat, f, p, o);
    chk("par_ok_pe", p, 0); chk("par_ok_vld", v, 1); chk("par_ok_dat", dat, 8'h03);
    exp_b.push_back(8'h03);

    // overrun, then the same-clk drain-and-reload case
    rdy_a = 1'b0;
    n_ov = ov_cnt[0];
    do_frame(0, 8'h12, 1'b0, 1'b1, 1'b0, 0, pre, v, dat, f, p, o);
    chk("ov1_vld", v, 1); chk("ov1_dat", dat, 8'h12);
    do_frame(0, 8'h34, 1'b0, 1'b1, 1'b0, 0, pre, v, dat, f, p, o);
    chk("ov2_ov", o, 1); chk("ov2_vld", v, 1); chk("ov2_dat", dat, 8'h12);
    chk("ov_count", ov_cnt[0] - n_ov, 1);
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    chk("ov_drain", vld_a, 0);
    exp_a.push_back(8'h12);
    do_frame(0, 8'h12, 1'b0, 1'b1, 1'b0, 0, pre, v, dat, f, p, o);
    chk("rl1_pre", pre, 0); chk("rl1_dat", dat, 8'h12);
    do_frame(0, 8'h34, 1'b0, 1'b1, 1'b1, 0, pre, v, dat, f, p, o);
    chk("rl2_pre", pre, 1); chk("rl2_ov", o, 0); chk("rl2_vld", v, 1); chk("rl2_dat", dat, 8'h34);
    exp_a.push_back(8'h12);
    exp_a.push_back(8'h34);
    rdy_a = 1'b1;
    @(negedge clk);
    chk("rl_drain", vld_a, 0);

    // reset mid-frame with a held word that must be discarded
    rdy_a = 1'b0;
    do_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0, 0, pre, v, dat, f, p, o);
    chk("5a_vld", v, 1);
    wait_tick_edge();
    @(negedge clk);
    rx_a = 1'b0;
    repeat (64) @(negedge clk);
    rx_a = 1'b1;
    repeat (256) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_vld", vld_a, 0); chk("mid_rst_dat", data_a, 0);
    chk("mid_rst_fe", fe_a, 0);   chk("mid_rst_pe", pe_a, 0); chk("mid_rst_ov", ov_a, 0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    n_rise = rise_cnt[0];
    rdy_a = 1'b1;
    do_frame(0, 8'h81, 1'b0, 1'b1, 1'b0, 0, pre, v, dat, f, p, o);
    chk("81_vld", v, 1); chk("81_dat", dat, 8'h81);
    chk("81_rise", rise_cnt[0] - n_rise, 1);
    exp_a.push_back(8'h81);

    // random frames against the frame-level model
    for (int n = 0; n < 12; n++) begin
      inst    = int'($urandom_range(0, 1));
      d       = 8'($urandom);
      kind    = int'($urandom_range(0, 3));
      stop    = (kind != 3);
      bad_par = (inst == 1) && (kind == 2);
      par     = (^d) ^ bad_par;
      good    = stop && !bad_par;
      do_frame(inst, d, par, stop, 1'b0, stop ? 0 : int'($urandom_range(0, 100)),
               pre, v, dat, f, p, o);
      chk("rnd_vld", v, good); chk("rnd_fe", f, !stop);
      chk("rnd_pe", p, stop && bad_par); chk("rnd_ov", o, 0);
      if (good) begin
        chk("rnd_dat", dat, d);
        if (inst == 0) exp_a.push_back(d); else exp_b.push_back(d);
      end
    end

    repeat (10) @(negedge clk);
    chk("q_a_size", got_a.size(), exp_a.size());
    chk("q_b_size", got_b.size(), exp_b.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) chk("q_a_item", got_a[i], exp_a[i]);
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) chk("q_b_item", got_b[i], exp_b[i]);
    chk("ov_b_total", ov_cnt[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
